// File: rtl/hub75_pkg.sv
// Shared HUB75 types, register map and status flag positions for the matrix
// driver and the capture/loopback monitor.
package hub75_pkg;

  typedef logic [5:0] pixel6_t;  // {r1,g1,b1,r2,g2,b2}
  typedef logic [2:0] rgb3_t;    // {r,g,b}

  localparam logic [1:0] REG_STATUS  = 2'd0;
  localparam logic [1:0] REG_OE_LAST = 2'd1;
  localparam logic [1:0] REG_CTRL    = 2'd2;

  localparam int FLAG_UNDERRUN = 0;
  localparam int FLAG_OVERRUN  = 1;
  localparam int FLAG_ROWSKIP  = 2;

endpackage

// File: rtl/hub75_input_sync.sv
// Multi-stage synchroniser for the asynchronous HUB75 inputs, with
// single-cycle rise/fall pulses derived from the synchronised levels.
module hub75_input_sync #(
  parameter int N           = 13,
  parameter int SYNC_STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] din,
  output logic [N-1:0] sync,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall
);

  logic [N-1:0] stage [SYNC_STAGES];
  logic [N-1:0] prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage[i] <= '0;
      prev <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) stage[i] <= stage[i-1];
      prev <= stage[SYNC_STAGES-1];
    end
  end

  assign sync = stage[SYNC_STAGES-1];
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/hub75_capture.sv
// HUB75 panel model: rebuilds the 32x32 RGB frame from the driver's wire
// signals and exposes frame contents and link status on an Avalon-MM slave.
module hub75_capture
  import hub75_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SCAN_ROWS   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hub_r1,
  input  logic        hub_g1,
  input  logic        hub_b1,
  input  logic        hub_r2,
  input  logic        hub_g2,
  input  logic        hub_b2,
  input  logic        hub_a,
  input  logic        hub_b,
  input  logic        hub_c,
  input  logic        hub_d,
  input  logic        hub_clk,
  input  logic        hub_lat,
  input  logic        hub_oe,
  input  logic [10:0] avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata
);

  localparam int ROWS = 2 * SCAN_ROWS;
  localparam int AW   = $clog2(SCAN_ROWS);
  localparam int RW   = $clog2(ROWS);
  localparam int IN_CLK = 10;
  localparam int IN_LAT = 11;
  localparam int IN_OE  = 12;

  logic [12:0] raw, sync, rise, fall;

  assign raw = {hub_oe, hub_lat, hub_clk, hub_d, hub_c, hub_b, hub_a,
                hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2};

  hub75_input_sync #(.N(13), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (raw),
    .sync  (sync),
    .rise  (rise),
    .fall  (fall)
  );

  logic    clk_rise, lat_rise, oe_low;
  pixel6_t pix_in;
  logic [AW-1:0] abcd;

  assign clk_rise = rise[IN_CLK];
  assign lat_rise = rise[IN_LAT];
  assign oe_low   = ~sync[IN_OE];
  assign pix_in   = sync[5:0];
  assign abcd     = sync[6 +: AW];

  pixel6_t       shift_buf [WIDTH];
  rgb3_t         frame_mem [ROWS][WIDTH];
  logic [5:0]    shift_cnt;
  logic          commit;
  logic [AW-1:0] commit_row, prev_row;
  logic          have_prev;
  logic [15:0]   frame_cnt, oe_cnt, oe_last;
  logic [2:0]    flags;
  logic [RW-1:0] top_idx, bot_idx;
  logic          ctrl_clear;
  logic [31:0]   rd_data;

  assign top_idx    = RW'(commit_row);
  assign bot_idx    = RW'(commit_row) + RW'(SCAN_ROWS);
  assign ctrl_clear = avs_write && avs_address[10] && (avs_address[1:0] == REG_CTRL)
                      && avs_writedata[0];

  // Commit runs one cycle after the latch edge so a shift landing on the
  // same edge as the latch is already in the buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) shift_buf[i] <= '0;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < WIDTH; c++) frame_mem[r][c] <= '0;
      shift_cnt  <= '0;
      commit     <= 1'b0;
      commit_row <= '0;
      prev_row   <= '0;
      have_prev  <= 1'b0;
      frame_cnt  <= '0;
      oe_cnt     <= '0;
      oe_last    <= '0;
      flags      <= '0;
    end else begin
      commit <= lat_rise;
      if (lat_rise) commit_row <= abcd;

      if (clk_rise) begin
        shift_buf[0] <= pix_in;
        for (int i = 1; i < WIDTH; i++) shift_buf[i] <= shift_buf[i-1];
      end

      if (commit) shift_cnt <= clk_rise ? 6'd1 : 6'd0;
      else if (clk_rise && shift_cnt != 6'd63) shift_cnt <= shift_cnt + 6'd1;

      if (commit) begin
        oe_cnt  <= '0;
        oe_last <= oe_cnt;
      end else if (oe_low && oe_cnt != 16'hffff) begin
        oe_cnt <= oe_cnt + 16'd1;
      end

      if (ctrl_clear) flags <= '0;

      if (commit) begin
        for (int c = 0; c < WIDTH; c++) begin
          frame_mem[top_idx][c] <= shift_buf[c][5:3];
          frame_mem[bot_idx][c] <= shift_buf[c][2:0];
        end
        if (shift_cnt < 6'(WIDTH)) flags[FLAG_UNDERRUN] <= 1'b1;
        if (shift_cnt > 6'(WIDTH)) flags[FLAG_OVERRUN]  <= 1'b1;
        if (have_prev) begin
          if (commit_row < prev_row) frame_cnt <= frame_cnt + 16'd1;
          if (commit_row != AW'(prev_row + 1'b1)) flags[FLAG_ROWSKIP] <= 1'b1;
        end
        prev_row  <= commit_row;
        have_prev <= 1'b1;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    if (!avs_address[10]) begin
      rd_data = {29'b0, frame_mem[avs_address[9:5]][avs_address[4:0]]};
    end else begin
      case (avs_address[1:0])
        REG_STATUS:  rd_data = {frame_cnt, 13'b0, flags};
        REG_OE_LAST: rd_data = {16'b0, oe_last};
        default:     rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset)         avs_readdata <= '0;
    else if (avs_read) avs_readdata <= rd_data;
  end

  logic unused_bits;
  assign unused_bits = ^{avs_writedata[31:1], rise[9:0], rise[12], fall,
                         sync[11:10], sync[9:6+AW]};

endmodule

// File: tb/tb_hub75_capture.sv
// Directed bench for hub75_capture: drives HUB75 rows and reads frame
// memory and status back over the Avalon slave.
module tb_hub75_capture;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        hub_r1 = 0, hub_g1 = 0, hub_b1 = 0, hub_r2 = 0, hub_g2 = 0, hub_b2 = 0;
  logic        hub_a = 0, hub_b = 0, hub_c = 0, hub_d = 0;
  logic        hub_clk = 0, hub_lat = 0, hub_oe = 1;
  logic [10:0] avs_address = '0;
  logic        avs_read = 0, avs_write = 0;
  logic [31:0] avs_writedata = '0;
  logic [31:0] avs_readdata;

  int total = 0;
  int bad   = 0;

  localparam logic [10:0] A_STATUS  = 11'h400;
  localparam logic [10:0] A_OE_LAST = 11'h401;
  localparam logic [10:0] A_CTRL    = 11'h402;

  hub75_capture dut (
    .clk           (clk),
    .reset         (reset),
    .hub_r1        (hub_r1),
    .hub_g1        (hub_g1),
    .hub_b1        (hub_b1),
    .hub_r2        (hub_r2),
    .hub_g2        (hub_g2),
    .hub_b2        (hub_b2),
    .hub_a         (hub_a),
    .hub_b         (hub_b),
    .hub_c         (hub_c),
    .hub_d         (hub_d),
    .hub_clk       (hub_clk),
    .hub_lat       (hub_lat),
    .hub_oe        (hub_oe),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_readdata  (avs_readdata)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    tick(1);
  endtask

  // checker
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // drivers
  task automatic set_data(input logic [5:0] d);
    {hub_r1, hub_g1, hub_b1, hub_r2, hub_g2, hub_b2} = d;
  endtask

  task automatic set_row(input logic [3:0] r);
    {hub_d, hub_c, hub_b, hub_a} = r;
  endtask

  task automatic shift_px(input logic [5:0] d);
    set_data(d);
    tick(2);
    hub_clk = 1'b1;
    tick(2);
    hub_clk = 1'b0;
  endtask

  task automatic latch(input logic [3:0] r);
    set_row(r);
    tick(2);
    hub_lat = 1'b1;
    tick(2);
    hub_lat = 1'b0;
    tick(6);
  endtask

  task automatic shift_and_latch(input logic [5:0] d, input logic [3:0] r);
    set_data(d);
    set_row(r);
    tick(2);
    hub_clk = 1'b1;
    hub_lat = 1'b1;
    tick(2);
    hub_clk = 1'b0;
    hub_lat = 1'b0;
    tick(6);
  endtask

  task automatic rd(input logic [10:0] a, output logic [31:0] v);
    avs_address = a;
    avs_read    = 1'b1;
    tick(1);
    avs_read    = 1'b0;
    v = avs_readdata;
  endtask

  task automatic wr(input logic [10:0] a, input logic [31:0] d);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    tick(1);
    avs_write     = 1'b0;
  endtask

  function automatic logic [10:0] pix(input int row, input int col);
    return {1'b0, 5'(row), 5'(col)};
  endfunction

  task automatic chk_reg(input string tag, input logic [10:0] a, input logic [31:0] exp);
    logic [31:0] v;
    rd(a, v);
    check(tag, v, exp);
  endtask

  task automatic chk_pix(input string tag, input int row, input int col, input logic [2:0] exp);
    chk_reg(tag, pix(row, col), {29'b0, exp});
  endtask

  initial begin
    // reset behaviour
    tick(2);
    avs_address = A_STATUS;
    avs_read    = 1'b1;
    tick(1);
    avs_read    = 1'b0;
    check("readdata_in_reset", avs_readdata, 32'h0);
    tick(1);
    reset = 1'b0;
    tick(2);
    chk_pix("reset_pix0", 0, 0, 3'b000);
    chk_reg("reset_status", A_STATUS, 32'h0);

    // full row on abcd=3: top r = k[0], bottom = green
    for (int k = 0; k < 32; k++) shift_px({k[0], 1'b0, 1'b0, 1'b0, 1'b1, 1'b0});
    latch(4'd3);
    chk_pix("row3_col31", 3, 31, 3'b000);
    chk_pix("row3_col30", 3, 30, 3'b100);
    chk_pix("row3_col15", 3, 15, 3'b000);
    chk_pix("row3_col0",  3, 0,  3'b100);
    chk_pix("row19_col0", 19, 0, 3'b010);
    chk_pix("row19_col31", 19, 31, 3'b010);
    chk_reg("status_clean", A_STATUS, 32'h0);
    wr(pix(3, 31), 32'h7);
    chk_pix("pix_write_ignored", 3, 31, 3'b000);

    // underrun: 30 pixels, two stale columns from the previous row remain
    for (int k = 0; k < 30; k++) shift_px({3'(k), ~3'(k)});
    latch(4'd4);
    chk_pix("under_row4_col0", 4, 0, 3'd5);
    chk_pix("under_row20_col0", 20, 0, 3'd2);
    chk_pix("under_stale_col30", 4, 30, 3'b100);
    chk_reg("status_underrun", A_STATUS, 32'h1);

    // overrun: 34 pixels, the two oldest are lost
    for (int k = 0; k < 34; k++) shift_px({3'(k), ~3'(k)});
    latch(4'd5);
    chk_pix("over_row5_col31", 5, 31, 3'd2);
    chk_pix("over_row21_col31", 21, 31, 3'd5);
    chk_pix("over_row5_col0", 5, 0, 3'd1);
    chk_reg("status_overrun", A_STATUS, 32'h3);
    wr(A_CTRL, 32'h1);
    chk_reg("status_cleared", A_STATUS, 32'h0);
    chk_reg("ctrl_reads_zero", A_CTRL, 32'h0);

    // output-enable accounting
    hub_oe = 1'b0;
    tick(100);
    hub_oe = 1'b1;
    latch(4'd6);
    chk_reg("oe_last_100", A_OE_LAST, 32'd100);
    latch(4'd7);
    chk_reg("oe_last_0", A_OE_LAST, 32'd0);
    chk_reg("status_after_oe", A_STATUS, 32'h1);

    // frame counter and row-skip detection
    do_reset();
    for (int r = 0; r < 16; r++) latch(4'(r));
    latch(4'd0);
    chk_reg("frame_cnt_1", A_STATUS, 32'h0001_0001);
    latch(4'd2);
    chk_reg("rowskip_set", A_STATUS, 32'h0001_0005);
    chk_reg("reg3_zero", 11'h403, 32'h0);

    // clock and latch rising together on the 32nd pixel
    do_reset();
    for (int k = 0; k < 31; k++) shift_px({3'(k), ~3'(k)});
    shift_and_latch(6'b101_011, 4'd9);
    chk_pix("same_edge_row9_col0", 9, 0, 3'd5);
    chk_pix("same_edge_row25_col0", 25, 0, 3'd3);
    chk_pix("same_edge_row9_col1", 9, 1, 3'd6);
    chk_pix("same_edge_row25_col31", 25, 31, 3'd7);
    chk_reg("same_edge_status", A_STATUS, 32'h0);

    // reset mid-row discards the partial row
    for (int k = 0; k < 10; k++) shift_px(6'b111111);
    do_reset();
    latch(4'd9);
    chk_pix("midreset_row9_col0", 9, 0, 3'd0);
    chk_pix("midreset_row9_col31", 9, 31, 3'd0);
    chk_pix("midreset_row25_col1", 25, 1, 3'd0);
    chk_pix("midreset_row3_col30", 3, 30, 3'd0);
    chk_reg("midreset_status", A_STATUS, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
